// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the MEM-stage load/store controller: RV32I width
// codes, memory access-size codes, FSM states and the default data-memory window.
package lsu_ctrl_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Must match the base used by the data-memory address translation.
   localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h0100_0000;
   localparam logic [31:0] DMEM_BYTES_DEFAULT = 32'h0010_0000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_SPLIT  = 2'd2
   } lsu_state_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction

   function automatic logic funct3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the loaded value from the low lanes of a little-endian word and
// sign/zero-extends it according to the RV32I load width code.
module lsu_load_align
   import lsu_ctrl_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] word,
   output logic [31:0] data
);

   always_comb begin
      case (funct3)
         F3_B:    data = {{24{word[7]}}, word[7:0]};
         F3_H:    data = {{16{word[15]}}, word[15:0]};
         F3_BU:   data = {24'd0, word[7:0]};
         F3_HU:   data = {16'd0, word[15:0]};
         F3_W:    data = word;
         default: data = word;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller driving a combinational data memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of splitting them.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
   parameter logic [31:0] DMEM_BYTES = DMEM_BYTES_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_fault,
   output logic [31:0] resp_data,
   output logic [31:0] dmem_address,
   output logic        dmem_read_write,
   output logic [31:0] dmem_data_in,
   output logic [1:0]  dmem_access_size,
   input  logic [31:0] dmem_data_out
);

   // Handshake: a request transfers on a rising edge with req_valid && req_ready;
   // req_ready is high only in IDLE and req_* are sampled only on that edge.

   lsu_state_t  state, next_state;
   logic        accept;
   logic        req_fault, req_range_bad, req_misaligned;
   logic [2:0]  req_bytes;
   logic [32:0] req_last, win_last;

   logic [2:0]  f3_q, f3_d;
   logic        store_q, store_d;
   logic [31:0] load_word, load_data;

   logic        resp_valid_d, resp_fault_d;
   logic [31:0] resp_data_d;
   logic [31:0] dmem_address_d, dmem_data_in_d;
   logic        dmem_read_write_d;
   logic [1:0]  dmem_access_size_d;

`ifndef LSU_MISALIGN_TRAP_EN
   logic [1:0]  cnt_q, cnt_d, last_q, last_d;
   logic [31:0] wdata_q, wdata_d, asm_q, asm_d, asm_next;
`endif

   assign req_ready = (state == ST_IDLE);
   assign accept    = req_valid && req_ready;

   // Bounds are compared at 33 bits so an access near 2^32 cannot wrap into range.
   assign req_bytes     = size_bytes(req_funct3[1:0]);
   assign req_last      = {1'b0, req_addr} + {30'd0, req_bytes} - 33'd1;
   assign win_last      = {1'b0, DMEM_BASE} + {1'b0, DMEM_BYTES} - 33'd1;
   assign req_range_bad = (req_addr < DMEM_BASE) || (req_last > win_last);
   assign req_misaligned = ((req_funct3[1:0] == SIZE_HALF) && req_addr[0]) ||
                           ((req_funct3[1:0] == SIZE_WORD) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_fault = !funct3_legal(req_funct3) || req_range_bad || req_misaligned;
   assign load_word = dmem_data_out;
`else
   assign req_fault = !funct3_legal(req_funct3) || req_range_bad;
   assign load_word = (state == ST_SPLIT) ? asm_next : dmem_data_out;

   // Byte k of a split access lands in lane k of the assembled word.
   always_comb begin
      asm_next = asm_q;
      asm_next[{cnt_q, 3'b000} +: 8] = dmem_data_out[7:0];
   end
`endif

   lsu_load_align u_load_align (
      .funct3 (f3_q),
      .word   (load_word),
      .data   (load_data)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (accept && !req_fault) begin
`ifdef LSU_MISALIGN_TRAP_EN
               next_state = ST_ACCESS;
`else
               next_state = req_misaligned ? ST_SPLIT : ST_ACCESS;
`endif
            end
         end
         ST_ACCESS: next_state = ST_IDLE;
`ifndef LSU_MISALIGN_TRAP_EN
         ST_SPLIT:  if (cnt_q == last_q) next_state = ST_IDLE;
`endif
         default:   next_state = ST_IDLE;
      endcase
   end

   // Next values for every registered output; the memory sees them one cycle later.
   always_comb begin
      f3_d               = f3_q;
      store_d            = store_q;
      resp_valid_d       = 1'b0;
      resp_fault_d       = 1'b0;
      resp_data_d        = 32'd0;
      dmem_address_d     = dmem_address;
      dmem_data_in_d     = dmem_data_in;
      dmem_access_size_d = dmem_access_size;
      dmem_read_write_d  = 1'b0;
`ifndef LSU_MISALIGN_TRAP_EN
      cnt_d   = cnt_q;
      last_d  = last_q;
      wdata_d = wdata_q;
      asm_d   = asm_q;
`endif
      case (state)
         ST_IDLE: begin
            if (accept) begin
               f3_d    = req_funct3;
               store_d = req_store;
               if (req_fault) begin
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
               end
`ifndef LSU_MISALIGN_TRAP_EN
               else if (req_misaligned) begin
                  dmem_address_d     = req_addr;
                  dmem_read_write_d  = req_store;
                  dmem_access_size_d = SIZE_BYTE;
                  dmem_data_in_d     = {24'd0, req_wdata[7:0]};
                  cnt_d   = 2'd0;
                  last_d  = (req_funct3[1:0] == SIZE_HALF) ? 2'd1 : 2'd3;
                  wdata_d = req_wdata;
                  asm_d   = 32'd0;
               end
`endif
               else begin
                  dmem_address_d     = req_addr;
                  dmem_read_write_d  = req_store;
                  dmem_access_size_d = req_funct3[1:0];
                  dmem_data_in_d     = req_wdata;
               end
            end
         end
         ST_ACCESS: begin
            resp_valid_d = 1'b1;
            resp_data_d  = store_q ? 32'd0 : load_data;
         end
`ifndef LSU_MISALIGN_TRAP_EN
         ST_SPLIT: begin
            asm_d = asm_next;
            if (cnt_q == last_q) begin
               resp_valid_d = 1'b1;
               resp_data_d  = store_q ? 32'd0 : load_data;
            end else begin
               cnt_d             = cnt_q + 2'd1;
               dmem_address_d    = dmem_address + 32'd1;
               dmem_read_write_d = store_q;
               dmem_data_in_d    = {24'd0, wdata_q[{cnt_d, 3'b000} +: 8]};
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         f3_q             <= 3'd0;
         store_q          <= 1'b0;
         resp_valid       <= 1'b0;
         resp_fault       <= 1'b0;
         resp_data        <= 32'd0;
         dmem_address     <= 32'd0;
         dmem_data_in     <= 32'd0;
         dmem_access_size <= 2'd0;
         dmem_read_write  <= 1'b0;
`ifndef LSU_MISALIGN_TRAP_EN
         cnt_q   <= 2'd0;
         last_q  <= 2'd0;
         wdata_q <= 32'd0;
         asm_q   <= 32'd0;
`endif
      end else begin
         f3_q             <= f3_d;
         store_q          <= store_d;
         resp_valid       <= resp_valid_d;
         resp_fault       <= resp_fault_d;
         resp_data        <= resp_data_d;
         dmem_address     <= dmem_address_d;
         dmem_data_in     <= dmem_data_in_d;
         dmem_access_size <= dmem_access_size_d;
         dmem_read_write  <= dmem_read_write_d;
`ifndef LSU_MISALIGN_TRAP_EN
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         wdata_q <= wdata_d;
         asm_q   <= asm_d;
`endif
      end
   end

endmodule
